tis_stack_node: RTL and testbench



---
 rtl/tis_pkg.sv | 15 +
 rtl/stack_mem.sv | 36 +++
 rtl/tis_stack_node.sv | 95 +++++++++
 tb/tb_tis_stack_node.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared definitions for tile-array nodes: word type, port direction indices
// and the default stack depth.
package tis_pkg;

    typedef logic signed [10:0] word_t;

    localparam int DIR_LEFT    = 0;
    localparam int DIR_RIGHT   = 1;
    localparam int DIR_UP      = 2;
    localparam int DIR_DOWN    = 3;

    localparam int STACK_DEPTH = 15;
    localparam int WORD_WIDTH  = $bits(word_t);

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port. Contents are not reset; the owner tracks which slots are valid.
module stack_mem
    import tis_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [4:0]       i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [4:0]       i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port; out-of-range addresses read as zero.
    always_comb begin
        o_rdata = {WIDTH{1'b0}};
        if (int'(i_raddr) < DEPTH) begin
            o_rdata = r_mem[i_raddr];
        end else begin
            o_rdata = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/tis_stack_node.sv
// LIFO stack node for the tile array; left port only.
// Optional macro STACK_LEVEL_EN adds the o_level output (current word count).
module tis_stack_node
    import tis_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [3:0]       o_write,
    output logic [3:0]       o_wready,
    input  logic             i_rreadyL,
    input  logic             i_readL,
    input  logic [WIDTH-1:0] i_left,
    output logic [WIDTH-1:0] o_out
`ifdef STACK_LEVEL_EN
    ,
    output logic [4:0]       o_level
`endif
);

    localparam logic [4:0] FULL_CNT = 5'(DEPTH);

    logic [4:0]       r_cnt;
    logic             w_nonempty;
    logic             w_notfull;
    logic             w_push;
    logic             w_pop;
    logic             w_we;
    logic [4:0]       w_waddr;
    logic [4:0]       w_raddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_nonempty = (r_cnt != 5'd0);
    assign w_notfull  = (r_cnt != FULL_CNT);
    assign w_push     = i_rreadyL & w_notfull;
    assign w_pop      = i_readL & w_nonempty;
    // Reset wins over a transfer in the same cycle: the word must not land.
    assign w_we       = w_push & rst;
    assign w_raddr    = r_cnt - 5'd1;

    // Simultaneous push and pop overwrites the current top in place.
    always_comb begin
        w_waddr = r_cnt;
        if (w_push && w_pop) begin
            w_waddr = r_cnt - 5'd1;
        end else begin
            w_waddr = r_cnt;
        end
    end

    // Stack pointer; memory is left uncleared on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 5'd0;
        end else if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 5'd1;
        end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - 5'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_left),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Handshake outputs and top-of-stack mux, driven from registered state only.
    always_comb begin
        o_write            = 4'b0000;
        o_wready           = 4'b0000;
        o_write[DIR_LEFT]  = w_nonempty;
        o_wready[DIR_LEFT] = w_notfull;
        if (w_nonempty) begin
            o_out = w_rdata;
        end else begin
            o_out = {WIDTH{1'b0}};
        end
    end

`ifdef STACK_LEVEL_EN
    assign o_level = r_cnt;
`endif

endmodule

// File: tb/tb_tis_stack_node.sv
// Directed bench for tis_stack_node: vector table plus hand-written sequences.
module tb_tis_stack_node;

    logic               clk;
    logic               rst;
    logic [3:0]         write;
    logic [3:0]         wready;
    logic               rreadyL;
    logic               readL;
    logic signed [10:0] left;
    logic signed [10:0] out;
`ifdef STACK_LEVEL_EN
    logic [4:0]         level;
`endif

    int total;
    int bad;

    typedef struct {
        logic rr;
        logic rd;
        int   lv;
        logic ew;
        logic ewr;
        int   eo;
        string nm;
    } vec_t;

    vec_t tbl[$];

    tis_stack_node dut (
        .clk       (clk),
        .rst       (rst),
        .o_write   (write),
        .o_wready  (wready),
        .i_rreadyL (rreadyL),
        .i_readL   (readL),
        .i_left    (left),
        .o_out     (out)
`ifdef STACK_LEVEL_EN
        ,
        .o_level   (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Outputs are checked mid-cycle, i.e. what a neighbour sees before the edge.
    task automatic chk_out(input string nm, input logic ew, input logic ewr, input int eo);
        check({nm, ".write"},  int'(write),  int'({3'b000, ew}));
        check({nm, ".wready"}, int'(wready), int'({3'b000, ewr}));
        check({nm, ".out"},    int'(out),    eo);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rr, input logic rd, input int lv);
        rreadyL = rr;
        readL   = rd;
        left    = 11'(lv);
    endtask

    task automatic add(input logic rr, input logic rd, input int lv,
                       input logic ew, input logic ewr, input int eo, input string nm);
        vec_t v;
        v.rr = rr; v.rd = rd; v.lv = lv; v.ew = ew; v.ewr = ewr; v.eo = eo; v.nm = nm;
        tbl.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 1'b0, 0);
        rst = 1'b0;

        // Vectors: inputs for the cycle, expected outputs seen during that cycle.
        add(1'b1, 1'b0,    5, 1'b0, 1'b1,    0, "push5");
        add(1'b1, 1'b0,   -7, 1'b1, 1'b1,    5, "push-7");
        add(1'b1, 1'b0,  999, 1'b1, 1'b1,   -7, "push999");
        add(1'b0, 1'b1,    0, 1'b1, 1'b1,  999, "pop999");
        add(1'b0, 1'b1,    0, 1'b1, 1'b1,   -7, "pop-7");
        add(1'b0, 1'b1,    0, 1'b1, 1'b1,    5, "pop5");
        add(1'b0, 1'b0,    0, 1'b0, 1'b1,    0, "drained");
        add(1'b0, 1'b1,    0, 1'b0, 1'b1,    0, "emptypop1");
        add(1'b0, 1'b1,    0, 1'b0, 1'b1,    0, "emptypop2");
        add(1'b0, 1'b1,    0, 1'b0, 1'b1,    0, "emptypop3");
        add(1'b1, 1'b0,    7, 1'b0, 1'b1,    0, "push7");
        add(1'b1, 1'b0,    8, 1'b1, 1'b1,    7, "push8");
        add(1'b1, 1'b1,   -3, 1'b1, 1'b1,    8, "pushpop");
        add(1'b0, 1'b0,    0, 1'b1, 1'b1,   -3, "afterpp");
        add(1'b0, 1'b1,    0, 1'b1, 1'b1,   -3, "pop-3");
        add(1'b0, 1'b1,    0, 1'b1, 1'b1,    7, "pop7");
        add(1'b0, 1'b0,    0, 1'b0, 1'b1,    0, "empty2");

        tick;
        tick;
        chk_out("reset", 1'b0, 1'b1, 0);
`ifdef STACK_LEVEL_EN
        check("reset.level", int'(level), 0);
`endif
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rr, tbl[i].rd, tbl[i].lv);
            #1;
            chk_out(tbl[i].nm, tbl[i].ew, tbl[i].ewr, tbl[i].eo);
            tick;
        end

        // Fill to capacity with 1..15.
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, 1'b0, i);
            #1;
            chk_out("fill", (i != 1), 1'b1, i - 1);
            tick;
        end
`ifdef STACK_LEVEL_EN
        check("full.level", int'(level), 15);
`endif
        // A held offer while full must not be taken.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 100);
            #1;
            chk_out("fullhold", 1'b1, 1'b0, 15);
            tick;
        end
        drive(1'b1, 1'b1, 100);
        #1;
        chk_out("fullpop", 1'b1, 1'b0, 15);
        tick;
        drive(1'b1, 1'b0, 100);
        #1;
        chk_out("freed", 1'b1, 1'b1, 14);
        tick;
        drive(1'b0, 1'b0, 0);
        #1;
        chk_out("heldaccepted", 1'b1, 1'b0, 100);
        tick;
        // Drain: 100 then 14 down to 1.
        for (int i = 15; i >= 1; i--) begin
            drive(1'b0, 1'b1, 0);
            #1;
            chk_out("drain", 1'b1, (i != 15), (i == 15) ? 100 : i);
            tick;
        end
        drive(1'b0, 1'b0, 0);
        #1;
        chk_out("drained2", 1'b0, 1'b1, 0);

        // Reset while a push is offered: the word must not be stored.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 20 + i);
            tick;
        end
        drive(1'b0, 1'b0, 0);
        #1;
        chk_out("before_rst", 1'b1, 1'b1, 24);
        drive(1'b1, 1'b0, 77);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        drive(1'b0, 1'b0, 0);
        #1;
        chk_out("midreset", 1'b0, 1'b1, 0);
`ifdef STACK_LEVEL_EN
        check("midreset.level", int'(level), 0);
`endif
        drive(1'b1, 1'b0, 55);
        tick;
        drive(1'b0, 1'b1, 0);
        #1;
        chk_out("postrst_push", 1'b1, 1'b1, 55);
        tick;
        drive(1'b0, 1'b0, 0);
        #1;
        chk_out("postrst_empty", 1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
